// File: rtl/cursor_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cursor_input_ctrl
// Description : Button debounce, cursor ownership with hold-to-repeat and
//               board clamping, and reveal/flag command issue over a
//               valid/ready handshake to the game logic.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 15000000,
    parameter int GRID_W          = 5,
    parameter int GRID_H          = 5,
    parameter int ORIGIN          = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_reveal,
    input  logic       btn_flag,
    output logic [9:0] cursor_x,
    output logic [8:0] cursor_y,
    output logic       move_pulse,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_flag,
    output logic [9:0] cmd_block
);

    localparam int NUM_BTN    = 6;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_REVEAL = 4;
    localparam int BTN_FLAG   = 5;

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  C_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] C_RPT_DELAY = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] C_RPT_RATE  = RPT_W'(REPEAT_RATE - 1);

    localparam logic [9:0] C_X_MIN  = 10'(ORIGIN);
    localparam logic [9:0] C_X_MAX  = 10'(ORIGIN + GRID_W - 1);
    localparam logic [8:0] C_Y_MIN  = 9'(ORIGIN);
    localparam logic [8:0] C_Y_MAX  = 9'(ORIGIN + GRID_H - 1);
    localparam logic [9:0] C_GRID_W = 10'(GRID_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and per-button debounce
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] db_q;
    logic [NUM_BTN-1:0] db_d;

    assign btn_raw = {btn_flag, btn_reveal, btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
            logic [DB_W-1:0] cnt_q;
            logic [DB_W-1:0] cnt_d;
            logic            lvl_d;

            // Counter only survives while the synced level disagrees; the
            // level flips on the DEBOUNCE_CYCLES-th consecutive disagreement.
            always_comb begin
                cnt_d = '0;
                lvl_d = db_q[gi];
                if (sync2_q[gi] != db_q[gi]) begin
                    if (cnt_q == C_DB_LAST) begin
                        lvl_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign db_d[gi] = lvl_d;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Direction select and clamped target position
    // ------------------------------------------------------------------
    logic       any_dir;
    logic [9:0] tgt_x;
    logic [8:0] tgt_y;
    logic       tgt_ok;

    assign any_dir = db_q[BTN_UP] | db_q[BTN_DOWN] | db_q[BTN_LEFT] | db_q[BTN_RIGHT];

    logic [9:0] cursor_x_q, cursor_x_d;
    logic [8:0] cursor_y_q, cursor_y_d;
    logic       move_pulse_q, move_pulse_d;

    always_comb begin
        tgt_x  = cursor_x_q;
        tgt_y  = cursor_y_q;
        tgt_ok = 1'b0;
        if (db_q[BTN_UP]) begin
            if (cursor_y_q > C_Y_MIN) begin
                tgt_y  = cursor_y_q - 9'd1;
                tgt_ok = 1'b1;
            end
        end else if (db_q[BTN_DOWN]) begin
            if (cursor_y_q < C_Y_MAX) begin
                tgt_y  = cursor_y_q + 9'd1;
                tgt_ok = 1'b1;
            end
        end else if (db_q[BTN_LEFT]) begin
            if (cursor_x_q > C_X_MIN) begin
                tgt_x  = cursor_x_q - 10'd1;
                tgt_ok = 1'b1;
            end
        end else if (db_q[BTN_RIGHT]) begin
            if (cursor_x_q < C_X_MAX) begin
                tgt_x  = cursor_x_q + 10'd1;
                tgt_ok = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Move / auto-repeat FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             do_move;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Release wins over a coincident expiry so no move happens on release.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        do_move   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_dir) begin
                    state_d   = S_FIRST;
                    rpt_cnt_d = C_RPT_DELAY;
                    do_move   = 1'b1;
                end
            end
            S_FIRST, S_REPEAT: begin
                if (!any_dir) begin
                    state_d   = S_IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == '0) begin
                    state_d   = S_REPEAT;
                    rpt_cnt_d = C_RPT_RATE;
                    do_move   = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        move_pulse_d = 1'b0;
        if (do_move && tgt_ok) begin
            cursor_x_d   = tgt_x;
            cursor_y_d   = tgt_y;
            move_pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cursor_x_q   <= C_X_MIN;
            cursor_y_q   <= C_Y_MIN;
            move_pulse_q <= 1'b0;
        end else begin
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            move_pulse_q <= move_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Command issue
    // ------------------------------------------------------------------
    logic [1:0] cmd_prev_q;
    logic       rev_rise;
    logic       flag_rise;
    logic [9:0] blk_col;
    logic [9:0] blk_row;
    logic [9:0] blk_idx;
    logic       cmd_valid_q, cmd_valid_d;
    logic       cmd_flag_q, cmd_flag_d;
    logic [9:0] cmd_block_q, cmd_block_d;

    assign rev_rise  = db_q[BTN_REVEAL] & ~cmd_prev_q[0];
    assign flag_rise = db_q[BTN_FLAG]   & ~cmd_prev_q[1];
    assign blk_col   = cursor_x_q - C_X_MIN;
    assign blk_row   = {1'b0, cursor_y_q} - {1'b0, C_Y_MIN};
    assign blk_idx   = blk_row * C_GRID_W + blk_col;

    // Edges are only taken when idle; the accept cycle itself drops them.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_flag_d  = cmd_flag_q;
        cmd_block_d = cmd_block_q;
        if (cmd_valid_q) begin
            if (cmd_ready) begin
                cmd_valid_d = 1'b0;
            end
        end else if (rev_rise || flag_rise) begin
            cmd_valid_d = 1'b1;
            cmd_flag_d  = ~rev_rise;
            cmd_block_d = blk_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_prev_q  <= 2'b00;
            cmd_valid_q <= 1'b0;
            cmd_flag_q  <= 1'b0;
            cmd_block_q <= '0;
        end else begin
            cmd_prev_q  <= {db_q[BTN_FLAG], db_q[BTN_REVEAL]};
            cmd_valid_q <= cmd_valid_d;
            cmd_flag_q  <= cmd_flag_d;
            cmd_block_q <= cmd_block_d;
        end
    end

    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign move_pulse = move_pulse_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_flag   = cmd_flag_q;
    assign cmd_block  = cmd_block_q;

endmodule
`default_nettype wire

// File: tb/tb_cursor_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cursor_input_ctrl
// Description : Directed self-checking bench for cursor_input_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_input_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] btn = 6'b0;   // {flag, reveal, right, left, down, up}
    logic       cmd_ready = 1'b0;
    logic [9:0] cursor_x;
    logic [8:0] cursor_y;
    logic       move_pulse;
    logic       cmd_valid;
    logic       cmd_flag;
    logic [9:0] cmd_block;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int p0 = 0;

    always #5 clk = ~clk;

    cursor_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8),
        .GRID_W         (5),
        .GRID_H         (5),
        .ORIGIN         (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn[0]),
        .btn_down  (btn[1]),
        .btn_left  (btn[2]),
        .btn_right (btn[3]),
        .btn_reveal(btn[4]),
        .btn_flag  (btn[5]),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .move_pulse(move_pulse),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_flag  (cmd_flag),
        .cmd_block (cmd_block)
    );

    always @(negedge clk) begin
        if (move_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
    endtask

    task automatic tap(input int idx);
        btn[idx] = 1'b1;
        tick(8);
        btn[idx] = 1'b0;
        tick(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        check("rst_x", 32'(cursor_x), 1);
        check("rst_y", 32'(cursor_y), 1);
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_pulse", 32'(move_pulse), 0);
        check("rst_block", 32'(cmd_block), 0);
        reset = 1'b1;
        tick(2);

        // 3-cycle glitch must not pass the debouncer
        btn[3] = 1'b1; tick(3); btn[3] = 1'b0; tick(12);
        check("glitch_x", 32'(cursor_x), 1);
        check("glitch_pulses", 32'(pulse_cnt), 0);

        // 12-cycle press -> one move
        p0 = pulse_cnt;
        btn[3] = 1'b1; tick(6);
        check("press_pre_x", 32'(cursor_x), 1);
        tick(1);
        check("press_x", 32'(cursor_x), 2);
        check("press_pulse", 32'(move_pulse), 1);
        tick(5); btn[3] = 1'b0; tick(12);
        check("press_hold_x", 32'(cursor_x), 2);
        check("press_pulses", 32'(pulse_cnt - p0), 1);

        // asynchronous reset mid-run
        #2 reset = 1'b0;
        #1;
        check("async_x", 32'(cursor_x), 1);
        check("async_y", 32'(cursor_y), 1);
        check("async_valid", 32'(cmd_valid), 0);
        check("async_pulse", 32'(move_pulse), 0);
        tick(1); reset = 1'b1; tick(2);

        // auto-repeat timing and right-edge clamp
        p0 = pulse_cnt;
        btn[3] = 1'b1; tick(7);
        check("rpt_first_x", 32'(cursor_x), 2);
        tick(19);
        check("rpt_26_x", 32'(cursor_x), 2);
        tick(1);
        check("rpt_27_x", 32'(cursor_x), 3);
        check("rpt_27_pulse", 32'(move_pulse), 1);
        tick(8);
        check("rpt_35_x", 32'(cursor_x), 4);
        tick(8);
        check("rpt_43_x", 32'(cursor_x), 5);
        tick(8);
        check("rpt_51_x", 32'(cursor_x), 5);
        check("rpt_51_pulse", 32'(move_pulse), 0);
        tick(8);
        check("rpt_59_x", 32'(cursor_x), 5);
        btn[3] = 1'b0; tick(12);
        check("rpt_pulses", 32'(pulse_cnt - p0), 4);

        // command held stable while pending
        do_reset();
        tap(3); tap(3); tap(1);
        check("cmd_pos_x", 32'(cursor_x), 3);
        check("cmd_pos_y", 32'(cursor_y), 2);
        btn[4] = 1'b1; tick(6);
        check("rev_pre_valid", 32'(cmd_valid), 0);
        tick(1);
        check("rev_valid", 32'(cmd_valid), 1);
        check("rev_flag", 32'(cmd_flag), 0);
        check("rev_block", 32'(cmd_block), 7);
        tick(10);
        check("rev_wait_valid", 32'(cmd_valid), 1);
        btn[4] = 1'b0; tick(10);
        tap(5);
        tap(3);
        check("hold_x", 32'(cursor_x), 4);
        check("hold_valid", 32'(cmd_valid), 1);
        check("hold_flag", 32'(cmd_flag), 0);
        check("hold_block", 32'(cmd_block), 7);
        // accept coinciding with a new reveal edge: edge dropped
        btn[4] = 1'b1; tick(6);
        cmd_ready = 1'b1; tick(1);
        check("acc_valid", 32'(cmd_valid), 0);
        cmd_ready = 1'b0; tick(5);
        check("acc_drop_valid", 32'(cmd_valid), 0);
        btn[4] = 1'b0; tick(10);

        // simultaneous directions and simultaneous commands
        do_reset();
        tap(3); tap(3); tap(1); tap(1);
        check("pri_pos_y", 32'(cursor_y), 3);
        p0 = pulse_cnt;
        btn[0] = 1'b1; btn[2] = 1'b1; tick(7);
        check("pri_x", 32'(cursor_x), 3);
        check("pri_y", 32'(cursor_y), 2);
        tick(1); btn[0] = 1'b0; btn[2] = 1'b0; tick(10);
        check("pri_pulses", 32'(pulse_cnt - p0), 1);
        btn[4] = 1'b1; btn[5] = 1'b1; tick(7);
        check("both_valid", 32'(cmd_valid), 1);
        check("both_flag", 32'(cmd_flag), 0);
        btn[4] = 1'b0; btn[5] = 1'b0; tick(10);
        cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
        check("both_acc", 32'(cmd_valid), 0);
        tap(3); tap(3); tap(1); tap(1);
        p0 = pulse_cnt;
        tap(3);
        check("clamp_r_x", 32'(cursor_x), 5);
        check("clamp_r_pulses", 32'(pulse_cnt - p0), 0);
        btn[5] = 1'b1; tick(7);
        check("flag_valid", 32'(cmd_valid), 1);
        check("flag_flag", 32'(cmd_flag), 1);
        check("flag_block", 32'(cmd_block), 19);
        btn[5] = 1'b0; tick(10);
        cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;

        // clamped up keeps repeating; direction swap keeps timing
        do_reset();
        p0 = pulse_cnt;
        btn[0] = 1'b1; tick(7);
        check("up_clamp_y", 32'(cursor_y), 1);
        check("up_clamp_pulse", 32'(move_pulse), 0);
        tick(29);
        check("up_clamp_pulses", 32'(pulse_cnt - p0), 0);
        btn[0] = 1'b0; btn[1] = 1'b1; tick(6);
        check("swap_pre_y", 32'(cursor_y), 1);
        tick(1);
        check("swap_y", 32'(cursor_y), 2);
        check("swap_pulse", 32'(move_pulse), 1);
        btn[1] = 1'b0; tick(12);
        check("swap_pulses", 32'(pulse_cnt - p0), 1);
        tap(3);
        check("after_idle_x", 32'(cursor_x), 2);

        // pending command lost on reset; held button re-debounced
        btn[4] = 1'b1; tick(7);
        check("pend_valid", 32'(cmd_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("pend_lost", 32'(cmd_valid), 0);
        tick(1); reset = 1'b1;
        tick(6);
        check("rehold_pre", 32'(cmd_valid), 0);
        tick(1);
        check("rehold_valid", 32'(cmd_valid), 1);
        check("rehold_block", 32'(cmd_block), 0);
        btn[4] = 1'b0; tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
